// File: rtl/scc_wave_pkg.sv
// rtl/scc_wave_pkg.sv - shared constants, tags and row remap for the SCC wave SRAM arbiter
package scc_wave_pkg;

    localparam int WAVE_LEN  = 32;
    localparam int MEM_DEPTH = 160;
    localparam int ID_W      = 3;
    localparam int IDX_W     = 5;
    localparam int ADDR_W    = 8;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_MIX = 1'b1
    } owner_e;

    typedef enum logic {
        SLOT_EMPTY   = 1'b0,
        SLOT_PENDING = 1'b1
    } cpu_slot_e;

    // Travels alongside each granted access until its read data returns.
    typedef struct packed {
        logic   rd;
        owner_e owner;
        logic   invalid;
    } tag_t;

    // In SCC mode channel 4 plays the waveform stored in row 3.
    function automatic logic [ID_W-1:0] wave_row(input logic [ID_W-1:0] id,
                                                 input logic            scci_enable);
        logic [ID_W-1:0] row;
        row = id;
        if (!scci_enable && id == ID_W'(4)) begin
            row = ID_W'(3);
        end
        return row;
    endfunction

endpackage

// File: rtl/scc_wave_sram_arbiter_if.sv
// rtl/scc_wave_sram_arbiter_if.sv - CPU, mixer and SRAM signal bundle of the wave SRAM arbiter
interface scc_wave_sram_arbiter_if;
    import scc_wave_pkg::*;

    logic              scci_enable;

    logic              cpu_req;
    logic              cpu_we;
    logic [ID_W-1:0]   cpu_id;
    logic [IDX_W-1:0]  cpu_a;
    logic [7:0]        cpu_d;
    logic              cpu_busy;
    logic              cpu_overrun;
    logic [7:0]        cpu_q;
    logic              cpu_q_en;

    logic              mix_req;
    logic [ID_W-1:0]   mix_id;
    logic [IDX_W-1:0]  mix_a;
    logic              mix_ack;
    logic [7:0]        mix_q;
    logic              mix_q_en;

    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_d;
    logic [7:0]        mem_q;

    modport slave (
        input  scci_enable,
        input  cpu_req, cpu_we, cpu_id, cpu_a, cpu_d,
        output cpu_busy, cpu_overrun, cpu_q, cpu_q_en,
        input  mix_req, mix_id, mix_a,
        output mix_ack, mix_q, mix_q_en,
        output mem_ce, mem_we, mem_addr, mem_d,
        input  mem_q
    );

    modport master (
        output scci_enable,
        output cpu_req, cpu_we, cpu_id, cpu_a, cpu_d,
        input  cpu_busy, cpu_overrun, cpu_q, cpu_q_en,
        output mix_req, mix_id, mix_a,
        input  mix_ack, mix_q, mix_q_en,
        input  mem_ce, mem_we, mem_addr, mem_d,
        output mem_q
    );

endinterface

// File: rtl/scc_wave_addr_map.sv
// rtl/scc_wave_addr_map.sv - channel id and sample index to wave SRAM address, with id validity
module scc_wave_addr_map
    import scc_wave_pkg::*;
#(
    parameter int NUM_CH = 5
) (
    input  logic              scci_enable,
    input  logic [ID_W-1:0]   id,
    input  logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] addr,
    output logic              valid
);

    localparam logic [ID_W:0] NUM_CH_L = (ID_W + 1)'(NUM_CH);

    logic [ID_W-1:0] row;

    assign row   = wave_row(id, scci_enable);
    assign addr  = ADDR_W'(32'(row) * WAVE_LEN + 32'(idx));
    assign valid = ({1'b0, id} < NUM_CH_L);

endmodule

// File: rtl/scc_wave_sram_arbiter.sv
// rtl/scc_wave_sram_arbiter.sv - one-port wave SRAM shared by CPU register path and mixer fetch
module scc_wave_sram_arbiter
    import scc_wave_pkg::*;
#(
    parameter int NUM_CH    = 5,
    parameter int AGE_LIMIT = 2
) (
    input  logic                 clk,
    input  logic                 nreset,
    scc_wave_sram_arbiter_if.slave bus
);

    localparam int              AGE_W   = $clog2(AGE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

    cpu_slot_e         slot_q;
    cpu_slot_e         slot_d;
    logic              capture;

    logic [ID_W-1:0]   pend_id;
    logic [IDX_W-1:0]  pend_a;
    logic [7:0]        pend_d;
    logic              pend_we;
    logic [AGE_W-1:0]  age_q;
    logic              overrun_q;

    logic              cpu_cand;
    logic              cpu_win;
    logic              mix_win;

    logic [ID_W-1:0]   c_id;
    logic [IDX_W-1:0]  c_a;
    logic [7:0]        c_d;
    logic              c_we;

    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ok;
    logic [ADDR_W-1:0] mix_addr;
    logic              mix_ok;

    logic              g_any;
    logic              g_we;
    logic              g_ok;
    logic              issue;
    logic [ADDR_W-1:0] g_addr;
    owner_e            g_owner;

    tag_t              s1_q;
    tag_t              s2_q;

    logic              mem_ce_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_d_q;
    logic [7:0]        cpu_q_q;
    logic              cpu_q_en_q;
    logic [7:0]        mix_q_q;
    logic              mix_q_en_q;

    // A pending CPU access blocks new CPU pulses, so it alone is the candidate then.
    assign cpu_cand = (slot_q == SLOT_PENDING) || bus.cpu_req;
    assign cpu_win  = cpu_cand && (!bus.mix_req || (age_q >= AGE_MAX));
    assign mix_win  = bus.mix_req && !cpu_win;

    assign c_id = (slot_q == SLOT_PENDING) ? pend_id : bus.cpu_id;
    assign c_a  = (slot_q == SLOT_PENDING) ? pend_a  : bus.cpu_a;
    assign c_d  = (slot_q == SLOT_PENDING) ? pend_d  : bus.cpu_d;
    assign c_we = (slot_q == SLOT_PENDING) ? pend_we : bus.cpu_we;

    scc_wave_addr_map #(.NUM_CH(NUM_CH)) u_cpu_map (
        .scci_enable (bus.scci_enable),
        .id          (c_id),
        .idx         (c_a),
        .addr        (cpu_addr),
        .valid       (cpu_ok)
    );

    scc_wave_addr_map #(.NUM_CH(NUM_CH)) u_mix_map (
        .scci_enable (bus.scci_enable),
        .id          (bus.mix_id),
        .idx         (bus.mix_a),
        .addr        (mix_addr),
        .valid       (mix_ok)
    );

    assign g_any   = cpu_win || mix_win;
    assign g_owner = cpu_win ? OWN_CPU : OWN_MIX;
    assign g_we    = cpu_win && c_we;
    assign g_ok    = cpu_win ? cpu_ok : mix_ok;
    assign g_addr  = cpu_win ? cpu_addr : mix_addr;
    assign issue   = g_any && g_ok;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            slot_q <= SLOT_EMPTY;
        end else begin
            slot_q <= slot_d;
        end
    end

    always_comb begin
        slot_d  = slot_q;
        capture = 1'b0;
        case (slot_q)
            SLOT_EMPTY: begin
                if (bus.cpu_req && !cpu_win) begin
                    slot_d  = SLOT_PENDING;
                    capture = 1'b1;
                end
            end
            SLOT_PENDING: begin
                if (cpu_win) begin
                    slot_d = SLOT_EMPTY;
                end
            end
            default: slot_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pend_id   <= '0;
            pend_a    <= '0;
            pend_d    <= '0;
            pend_we   <= 1'b0;
            age_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (capture) begin
                pend_id <= bus.cpu_id;
                pend_a  <= bus.cpu_a;
                pend_d  <= bus.cpu_d;
                pend_we <= bus.cpu_we;
            end
            if (slot_q == SLOT_PENDING && bus.cpu_req) begin
                overrun_q <= 1'b1;
            end
            // Age counts edges lost by a waiting CPU access; saturates so CPU wins next.
            if (cpu_win) begin
                age_q <= '0;
            end else if (cpu_cand && age_q < AGE_MAX) begin
                age_q <= age_q + 1'b1;
            end
        end
    end

    // Invalid ids still occupy a grant slot but never touch the SRAM.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mem_ce_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_d_q    <= '0;
        end else begin
            mem_ce_q <= issue;
            mem_we_q <= issue && g_we;
            mem_d_q  <= (issue && g_we) ? c_d : 8'h00;
            if (issue) begin
                mem_addr_q <= g_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            cpu_q_q    <= '0;
            cpu_q_en_q <= 1'b0;
            mix_q_q    <= '0;
            mix_q_en_q <= 1'b0;
        end else begin
            s1_q       <= '{rd: g_any && !g_we, owner: g_owner, invalid: !g_ok};
            s2_q       <= s1_q;
            cpu_q_en_q <= s2_q.rd && (s2_q.owner == OWN_CPU);
            mix_q_en_q <= s2_q.rd && (s2_q.owner == OWN_MIX);
            if (s2_q.rd && s2_q.owner == OWN_CPU) begin
                cpu_q_q <= s2_q.invalid ? 8'hFF : bus.mem_q;
            end
            if (s2_q.rd && s2_q.owner == OWN_MIX) begin
                mix_q_q <= s2_q.invalid ? 8'h00 : bus.mem_q;
            end
        end
    end

    assign bus.cpu_busy    = (slot_q == SLOT_PENDING);
    assign bus.cpu_overrun = overrun_q;
    assign bus.cpu_q       = cpu_q_q;
    assign bus.cpu_q_en    = cpu_q_en_q;
    // Combinational ack is forced low while reset is held so every output reads 0.
    assign bus.mix_ack     = nreset && mix_win;
    assign bus.mix_q       = mix_q_q;
    assign bus.mix_q_en    = mix_q_en_q;
    assign bus.mem_ce      = mem_ce_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_d       = mem_d_q;

endmodule

// File: doc/scc_wave_sram_arbiter.md
Name: scc_wave_sram_arbiter

Overview:
- Shares the single-port 160x8 wave-table SRAM (5 channels x 32 samples) between two requesters: the CPU register path (reads and writes) and the channel mixer's sample fetch (reads only).
- Sits between the register block and the mixer inside the SCC core.
- Schedules one memory cycle per clock, with mixer priority bounded by CPU aging.
- Applies the SCC-mode shared-waveform remap and tags returned read data back to its owner.

Parameters:
- NUM_CH, 5, number of valid channel ids (0..NUM_CH-1).
- AGE_LIMIT, 2, maximum consecutive cycles a pending CPU access may lose to the mixer.

Ports:
- clk  in  1  system clock.
- nreset  in  1  asynchronous active-low reset.
- scci_enable  in  1  1 = SCC-I mode (5 independent waves); 0 = SCC mode (id 4 shares wave row 3).
- cpu_req  in  1  one-cycle access pulse.
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
- cpu_id  in  3  channel id.
- cpu_a  in  5  sample index.
- cpu_d  in  8  write data.
- cpu_busy  out  1  CPU access pending, not yet granted.
- cpu_overrun  out  1  sticky: a cpu_req arrived while cpu_busy=1.
- cpu_q  out  8  CPU read data.
- cpu_q_en  out  1  cpu_q valid, one-cycle pulse.
- mix_req  in  1  level; held until acknowledged.
- mix_id  in  3  channel id.
- mix_a  in  5  sample index.
- mix_ack  out  1  combinational grant; the request is consumed at this clock edge.
- mix_q  out  8  mixer read data.
- mix_q_en  out  1  mix_q valid, one-cycle pulse.
- mem_ce  out  1  SRAM cycle enable, registered.
- mem_we  out  1  SRAM write enable, registered.
- mem_addr  out  8  row*32 + index, registered.
- mem_d  out  8  SRAM write data, registered.
- mem_q  in  8  SRAM read data, valid one clock after mem_ce.

Behaviour:
- Reset: every output is 0; the CPU pending slot is empty; age=0; in-flight reads are discarded, so no q_en is issued after reset release for pre-reset accesses.
- CPU slot states:
  - EMPTY: cpu_req granted the same edge if the grant rule allows it; otherwise it is captured into PENDING (id, a, d, we latched) and cpu_busy=1 from the next cycle.
  - PENDING: cpu_req is dropped and sets cpu_overrun.
  - Returns to EMPTY on grant.
- Grant rule, each edge, CPU candidate = PENDING or (EMPTY and cpu_req):
  - CPU wins if it is a candidate and (mix_req=0 or age>=AGE_LIMIT).
  - Otherwise the mixer wins if mix_req=1.
  - mix_ack = mix_req and not CPU win.
- Age: +1 on each edge a CPU candidate loses, cleared on CPU grant, saturating at AGE_LIMIT.
- Row remap: row = id, except id 4 maps to row 3 when scci_enable=0. This applies to both requesters, so a CPU write to id 4 in SCC mode modifies row 3.
- Invalid id (>= NUM_CH):
  - No SRAM cycle is issued (mem_ce=0); the grant and q_en timing are unchanged.
  - Reads return 0xFF to the CPU and 0x00 to the mixer.
  - Writes are discarded.
- Timing, grant at edge k:
  - mem_* are driven in cycle k..k+1.
  - The SRAM samples at k+1.
  - For reads, the owner's q/q_en are registered at edge k+2, so q_en is high for exactly the cycle after k+2.
  - Writes produce no q_en.
- Owner tags: carried through a 2-stage registered pipeline (owner, read, invalid). Back-to-back grants every cycle are legal, including an alternating CPU/mixer mix.
- Read-after-write: a CPU write granted at edge k followed by a mixer read of the same address granted at edge k+1 returns the new data. The SRAM is write-first; the arbiter adds no bypass.
- mem_d and mem_we are 0 on read and idle cycles; mem_addr holds its last value when idle.

Decomposition:
- Package scc_wave_pkg holds:
  - constants WAVE_LEN=32, MEM_DEPTH=160, ID_W=3, IDX_W=5, ADDR_W=8;
  - the owner encoding (OWN_CPU, OWN_MIX);
  - function wave_row(id, scci_enable) for the remap.
- One sub-module, scc_wave_addr_map (combinational id/index to mem_addr plus a valid flag), instanced twice (CPU and mixer) so both paths share identical remap logic.

Test Plan:
- Idle mixer:
  - Stimulus: scci_enable=1; CPU write id2 a5 d=0x3C, then a CPU read of the same location.
  - Required: mem_addr=0x45 with mem_we=1 one cycle after the write request; the read yields cpu_q=0x3C with cpu_q_en two cycles after its request; cpu_busy stays 0 throughout.
- Aging:
  - Stimulus: mix_req held high, continuously re-requesting; cpu_req pulsed once.
  - Required: mix_ack is high for 2 edges, then low for 1 edge while the CPU is granted; cpu_busy is high for exactly 2 cycles; age returns to 0.
- SCC mode shared row:
  - Stimulus: scci_enable=0; CPU write id4 a0 d=0x7F.
  - Required: mem_addr=0x60; a mixer read of id3 a0 returns mix_q=0x7F.
  - With scci_enable=1, a mixer read of id4 a0 uses mem_addr=0x80.
- Invalid id and overrun:
  - Stimulus: CPU read with id 6.
  - Required: mem_ce stays 0, cpu_q=0xFF with cpu_q_en at the normal latency.
  - Stimulus: two cpu_req pulses while the mixer holds the bus.
  - Required: cpu_overrun=1 and only the first access executes.
- Back-to-back pipeline:
  - Stimulus: alternating mixer and CPU reads every cycle for 8 cycles with distinct preloaded data.
  - Required: each q_en pulse goes to the correct owner with the correct byte, and no pulses are lost or duplicated.
- Reset mid-read:
  - Stimulus: nreset asserted one cycle after a mixer read grant.
  - Required: all outputs go to 0 immediately, and no mix_q_en pulse appears after release.
